// File: rtl/hyperbus_pkg.sv
// Shared HyperBus PHY definitions: delay controller FSM states, default tap/settle constants
// and the tap clamping helper.
package hyperbus_pkg;

  localparam int unsigned HB_NUM_TAPS      = 4;
  localparam int unsigned HB_IDLE_QUAL     = 2;
  localparam int unsigned HB_SETTLE_CYCLES = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    QUAL   = 2'd1,
    GATE   = 2'd2,
    SETTLE = 2'd3
  } delay_state_t;

  // Saturate a requested tap index to the highest implemented tap.
  function automatic logic [31:0] clamp_tap(input logic [31:0] req, input logic [31:0] max_tap);
    return (req > max_tap) ? max_tap : req;
  endfunction

endpackage

// File: rtl/hyperbus_delay_ctrl.sv
// RWDS delay-line tap controller: waits for a qualified PHY idle window, then switches
// the tap select while RX capture is blocked, and holds the block through a settle window.
module hyperbus_delay_ctrl
  import hyperbus_pkg::*;
#(
  parameter int unsigned NUM_TAPS      = HB_NUM_TAPS,
  parameter int unsigned RST_DELAY     = 0,
  parameter int unsigned IDLE_QUAL     = HB_IDLE_QUAL,
  parameter int unsigned SETTLE_CYCLES = HB_SETTLE_CYCLES
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] cfg_delay_i,
  input  logic        cfg_valid_i,
  output logic        cfg_ready_o,
  input  logic        phy_idle_i,
  output logic [31:0] delay_o,
  output logic        rx_block_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        clamp_o
);

  localparam int unsigned MAX_CNT = (IDLE_QUAL > SETTLE_CYCLES) ? IDLE_QUAL : SETTLE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [31:0] MAX_TAP = 32'(NUM_TAPS - 1);
  localparam logic [31:0] RST_TAP = 32'(RST_DELAY);
  localparam logic [CNT_W-1:0] QUAL_LAST   = CNT_W'(IDLE_QUAL - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  delay_state_t     state_q, state_d;
  logic [31:0]      pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      delay_d;
  logic             rx_block_d, busy_d, done_d, clamp_d;

  logic             accept;
  logic [31:0]      req_tap;
  logic             req_clamped;

  // Requests are only taken while no switch is committed.
  assign cfg_ready_o = (state_q == IDLE) || (state_q == QUAL);
  assign accept      = cfg_valid_i && cfg_ready_o;
  assign req_tap     = clamp_tap(cfg_delay_i, MAX_TAP);
  assign req_clamped = cfg_delay_i > MAX_TAP;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    delay_d = delay_o;
    done_d  = 1'b0;
    clamp_d = accept && req_clamped;

    case (state_q)
      IDLE: begin
        if (accept) begin
          pend_d = req_tap;
          if (req_tap == delay_o) begin
            done_d = 1'b1;
          end else begin
            state_d = QUAL;
            cnt_d   = '0;
          end
        end
      end
      QUAL: begin
        // A newer request replaces the pending one but keeps the idle count running.
        if (accept) begin
          pend_d = req_tap;
        end
        if (accept && (req_tap == delay_o)) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else if (!phy_idle_i) begin
          cnt_d = '0;
        end else if (cnt_q == QUAL_LAST) begin
          state_d = GATE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GATE: begin
        delay_d = pend_q;
        cnt_d   = '0;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    rx_block_d = (state_d == GATE) || (state_d == SETTLE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      pend_q     <= RST_TAP;
      cnt_q      <= '0;
      delay_o    <= RST_TAP;
      rx_block_o <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      clamp_o    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      delay_o    <= delay_d;
      rx_block_o <= rx_block_d;
      busy_o     <= busy_d;
      done_o     <= done_d;
      clamp_o    <= clamp_d;
    end
  end

endmodule

// File: tb/tb_hyperbus_delay_ctrl.sv
// Self-checking bench for hyperbus_delay_ctrl: directed scenarios plus random traffic,
// every cycle compared against a transaction-level reference model.
module tb_hyperbus_delay_ctrl;

  localparam int unsigned NUM_TAPS      = 4;
  localparam int unsigned RST_DELAY     = 0;
  localparam int unsigned IDLE_QUAL     = 2;
  localparam int unsigned SETTLE_CYCLES = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cfg_delay;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        phy_idle;
  logic [31:0] delay;
  logic        rx_block;
  logic        busy;
  logic        done;
  logic        clamp;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: applied tap, pending tap, consecutive idle run, remaining blocked cycles.
  int unsigned m_delay, m_pend, m_run, m_block;
  bit          m_wait, m_done, m_clamp;

  hyperbus_delay_ctrl #(
    .NUM_TAPS(NUM_TAPS), .RST_DELAY(RST_DELAY),
    .IDLE_QUAL(IDLE_QUAL), .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .clk_i(clk), .rst_i(rst), .cfg_delay_i(cfg_delay), .cfg_valid_i(cfg_valid),
    .cfg_ready_o(cfg_ready), .phy_idle_i(phy_idle), .delay_o(delay),
    .rx_block_o(rx_block), .busy_o(busy), .done_o(done), .clamp_o(clamp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_delay = RST_DELAY;
    m_pend  = RST_DELAY;
    m_run   = 0;
    m_block = 0;
    m_wait  = 1'b0;
    m_done  = 1'b0;
    m_clamp = 1'b0;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_tick();
    bit          acc;
    int unsigned p;
    acc     = cfg_valid && (m_block == 0);
    p       = (cfg_delay > NUM_TAPS - 1) ? NUM_TAPS - 1 : cfg_delay;
    m_clamp = acc && (cfg_delay > NUM_TAPS - 1);
    m_done  = 1'b0;
    if (m_block > 0) begin
      if (m_block == SETTLE_CYCLES + 1) m_delay = m_pend;
      if (m_block == 1) m_done = 1'b1;
      m_block--;
    end else if (m_wait) begin
      if (acc) m_pend = p;
      if (acc && p == m_delay) begin
        m_wait = 1'b0;
        m_run  = 0;
        m_done = 1'b1;
      end else if (phy_idle) begin
        m_run++;
        if (m_run == IDLE_QUAL) begin
          m_wait  = 1'b0;
          m_run   = 0;
          m_block = SETTLE_CYCLES + 1;
        end
      end else begin
        m_run = 0;
      end
    end else if (acc) begin
      if (p == m_delay) begin
        m_done = 1'b1;
      end else begin
        m_wait = 1'b1;
        m_pend = p;
        m_run  = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("delay", delay, m_delay);
    chk("rx_block", rx_block, m_block > 0);
    chk("busy", busy, m_wait || (m_block > 0));
    chk("done", done, m_done);
    chk("clamp", clamp, m_clamp);
    chk("ready", cfg_ready, m_block == 0);
  endtask

  // Apply inputs for one cycle, clock, then check outputs just after the edge.
  task automatic step(input logic v, input logic [31:0] d, input logic idle);
    cfg_valid = v;
    cfg_delay = d;
    phy_idle  = idle;
    @(posedge clk);
    model_tick();
    #1;
    compare_all();
  endtask

  initial begin
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_delay = '0;
    phy_idle  = 1'b1;
    model_reset();
    #1;
    chk("rst_delay", delay, RST_DELAY);
    chk("rst_rx_block", rx_block, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic switch to tap 3 with the PHY idle throughout.
    step(1'b1, 32'd3, 1'b1);
    chk("t1_clamp", clamp, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      step(1'b0, 32'd0, 1'b1);
      if (k == 2) begin
        chk("t1_gate_rxblk", rx_block, 1'b1);
        chk("t1_gate_delay", delay, 32'd0);
      end
      if (k == 3) chk("t1_delay_c4", delay, 32'd3);
      if (k == 7) begin
        chk("t1_done_c8", done, 1'b1);
        chk("t1_ready_c8", cfg_ready, 1'b1);
      end
    end

    // Request equal to the current tap completes without blocking.
    step(1'b1, 32'd3, 1'b1);
    chk("eq_done", done, 1'b1);
    chk("eq_rxblk", rx_block, 1'b0);
    chk("eq_busy", busy, 1'b0);
    step(1'b0, 32'd0, 1'b1);

    // Move to tap 0, then an out-of-range request saturates to 3.
    step(1'b1, 32'd0, 1'b1);
    repeat (8) step(1'b0, 32'd0, 1'b1);
    step(1'b1, 32'd9, 1'b1);
    chk("clamp_pulse", clamp, 1'b1);
    step(1'b0, 32'd0, 1'b1);
    chk("clamp_single", clamp, 1'b0);
    repeat (8) step(1'b0, 32'd0, 1'b1);
    chk("clamp_final", delay, 32'd3);

    // Idle qualification must restart when the PHY goes busy.
    step(1'b1, 32'd2, 1'b1);
    step(1'b0, 32'd0, 1'b1);
    step(1'b0, 32'd0, 1'b0);
    step(1'b0, 32'd0, 1'b1);
    chk("qual_no_gate", rx_block, 1'b0);
    step(1'b0, 32'd0, 1'b1);
    chk("qual_gate", rx_block, 1'b1);
    chk("qual_delay_hold", delay, 32'd3);
    repeat (6) step(1'b0, 32'd0, 1'b0);
    chk("qual_final", delay, 32'd2);

    // Coalescing: request 1, then 2 before qualification; tap 1 is never applied.
    step(1'b1, 32'd1, 1'b0);
    step(1'b1, 32'd2, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 32'd0, 1'b1);
      chk("coal_not1", delay == 32'd1, 1'b0);
    end
    chk("coal_final", delay, 32'd2);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(99) < 30) ? 1'b1 : 1'b0, 32'($urandom_range(7)),
           ($urandom_range(99) < 75) ? 1'b1 : 1'b0);
    end
    repeat (12) step(1'b0, 32'd0, 1'b1);

    // Reset asserted mid-SETTLE clears everything at once and suppresses completion.
    step(1'b1, 32'((m_delay + 1) % NUM_TAPS), 1'b1);
    repeat (4) step(1'b0, 32'd0, 1'b1);
    chk("rst_mid_in_settle", rx_block, 1'b1);
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    chk("rst_mid_delay", delay, RST_DELAY);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 32'd0, 1'b1);
      chk("rst_mid_no_done", done, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
